ext_data_mem: RTL and testbench
===============================

Name: ext_data_mem

Overview:
- Word-organised data memory with a configurable number of wait states.
- Sits directly downstream of the load-store unit. Consumes its request, write-enable, byte-enable, address and write-data outputs. Returns read data and a one-cycle ready pulse that releases the core stall.
- Accepts one transaction at a time. Byte-enable writes. Read data is registered and held.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from the acceptance edge to the cycle in which ready_o is high; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- mem_req_i  input  1  transaction request.
- write_enable_i  input  1  1 = write, 0 = read.
- byte_enable_i  input  4  byte lanes to write; bit n selects bits [8n+7:8n]; ignored for reads.
- addr_i  input  32  byte address.
- write_data_i  input  32  write data, already lane-replicated by the LSU.
- read_data_o  output  32  registered read data.
- ready_o  output  1  single-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high. While rst_i is high, state = IDLE, ready_o = 0, read_data_o = 0, wait counter = 0.
  - Memory array contents are not reset.
  - Reset mid-transaction discards the transaction. A pending write is not committed, and no ready_o is produced after reset releases.
- Addressing:
  - word index = addr_i[log2(DEPTH_WORDS)+1 : 2].
  - Higher address bits are ignored, so addresses alias and wrap modulo DEPTH_WORDS*4.
  - addr_i[1:0] is ignored; lane selection comes only from byte_enable_i.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_req_i = 1 at a rising edge, the transaction is accepted. write_enable_i, byte_enable_i, word index and write_data_i are latched into request registers.
  - If LATENCY = 1, go to RESP. Otherwise go to WAIT with counter = LATENCY-1.
  - If mem_req_i = 0, stay in IDLE.
- WAIT:
  - The counter decrements each edge.
  - When the counter reaches 1 at a rising edge, go to RESP.
  - Input changes during WAIT are ignored; only the latched request is used.
- Entry into RESP (the same rising edge as the transition):
  - Write: for each set bit of the latched byte enable, the corresponding byte of the addressed word is updated. The byte enable 0000 updates nothing but still completes.
  - Read: the full addressed word is loaded into read_data_o.
  - Write: read_data_o keeps its previous value.
- RESP:
  - ready_o = 1 for exactly this one cycle.
  - The next edge always returns to IDLE, regardless of mem_req_i. The request still held by the stalled core in this cycle belongs to the completed transaction and must not be re-accepted.
- Throughput: a request held continuously high is accepted every LATENCY+1 cycles. The first acceptance is at the first edge in IDLE.
- Latency:
  - Acceptance edge at cycle 0; ready_o high in cycle LATENCY.
  - read_data_o is valid from cycle LATENCY and holds until the next read completes.
- Compatibility with the LSU stall logic:
  - ready_o is never asserted in the first cycle of a request, since LATENCY ≥ 1.
  - ready_o is never asserted outside RESP.
- Read-after-write to the same word in the next transaction returns the newly written bytes. No bypass is needed because the write commits before the next acceptance.
- An illegal LATENCY (outside 1..15) is rejected at elaboration.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle during WAIT of a write of 0xDEADBEEF to 0x10 → ready_o and read_data_o go to 0 immediately. After release, no ready_o pulse occurs, and a read of 0x10 returns the pre-write contents.
- Word write/read, LATENCY=2: write 0x12345678 to 0x40 with be=1111. With acceptance at cycle 0, ready_o is high only in cycle 2. The following read of 0x40 has ready_o in cycle 5 (re-accepted at cycle 3 after the RESP→IDLE edge) with read_data_o = 0x12345678, held until the next read.
- Byte lanes: preload 0x00000000 at 0x80. Write 0xABABABAB with be=0100, then 0xCDCDCDCD with be=0001. Read 0x80 → 0x00AB00CD. A write with be=0000 leaves the word unchanged and still pulses ready_o once.
- Held request: mem_req_i held high for 10 cycles with LATENCY=2 → acceptances at cycles 0, 3, 6, 9. ready_o pulses in cycles 2, 5, 8, never in consecutive cycles.
- Input change after acceptance: accept a read of 0x04, then change addr_i to 0x08 and write_enable_i to 1 during WAIT → the read of 0x04 completes and no write occurs.
- Aliasing and LATENCY=1: with DEPTH_WORDS=1024, write 0x55AA55AA to 0x1004. Read 0x0004 → 0x55AA55AA, with ready_o in the cycle after acceptance.

Source files
------------

// File: rtl/ext_data_mem.sv
// ============================================================================
// Module   : ext_data_mem
// Purpose  : Word-organised data memory with byte-enable writes and a fixed
//            number of wait states before a single-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o
);

    localparam int         AW          = $clog2(DEPTH_WORDS);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;
    localparam logic [3:0] C_WAIT_INIT = 4'(LATENCY - 1);
    localparam bit         C_SINGLE    = (LATENCY == 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("ext_data_mem: LATENCY must be in 1..15");
        end
        if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("ext_data_mem: DEPTH_WORDS must be a power of two >= 2");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [3:0]    r_count;
    logic          r_we;
    logic [3:0]    r_be;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_commit_wr;
    logic          w_sel_we;
    logic [3:0]    w_sel_be;
    logic [AW-1:0] w_sel_idx;
    logic [31:0]   w_sel_wdata;
    logic [AW-1:0] w_in_idx;
    logic          w_unused_addr;

    assign w_in_idx      = addr_i[AW+1:2];
    assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign w_accept     = (r_state == ST_IDLE) && mem_req_i;
    assign w_enter_resp = (w_accept && C_SINGLE) ||
                          ((r_state == ST_WAIT) && (r_count == 4'd1));

    // With a single wait state the commit happens on the acceptance edge,
    // so the live inputs are used instead of the request registers.
    assign w_sel_we    = (r_state == ST_IDLE) ? write_enable_i : r_we;
    assign w_sel_be    = (r_state == ST_IDLE) ? byte_enable_i  : r_be;
    assign w_sel_idx   = (r_state == ST_IDLE) ? w_in_idx       : r_idx;
    assign w_sel_wdata = (r_state == ST_IDLE) ? write_data_i   : r_wdata;

    assign w_commit_wr = w_enter_resp && w_sel_we && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        r_we    <= write_enable_i;
                        r_be    <= byte_enable_i;
                        r_idx   <= w_in_idx;
                        r_wdata <= write_data_i;
                        if (C_SINGLE) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= C_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                // RESP always falls back to IDLE so the still-held request
                // of the completed transaction is not accepted twice.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_enter_resp && !w_sel_we) begin
                r_rdata <= r_mem[w_sel_idx];
            end
        end
    end

    generate
        for (genvar b = 0; b < 4; b++) begin : g_lane
            always_ff @(posedge clk_i) begin
                if (w_commit_wr && w_sel_be[b]) begin
                    r_mem[w_sel_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
                end
            end
        end
    endgenerate

    assign read_data_o = r_rdata;
    assign ready_o     = (r_state == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_ext_data_mem.sv
// ============================================================================
// Module   : tb_ext_data_mem
// Purpose  : Self-checking bench for ext_data_mem (LATENCY=2 and LATENCY=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ext_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ready;

    always #5 clk = ~clk;

    ext_data_mem #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_req_i      (a_req),
        .write_enable_i (a_we),
        .byte_enable_i  (a_be),
        .addr_i         (a_addr),
        .write_data_i   (a_wdata),
        .read_data_o    (a_rdata),
        .ready_o        (a_ready)
    );

    ext_data_mem #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_req_i      (b_req),
        .write_enable_i (b_we),
        .byte_enable_i  (4'hF),
        .addr_i         (b_addr),
        .write_data_i   (b_wdata),
        .read_data_o    (b_rdata),
        .ready_o        (b_ready)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [15];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q [$];
    logic        prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse on DUT A consumes one expected read_data_o.
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            chk("ready_not_back_to_back", {31'b0, prev_rdy}, 32'd0);
            if (sb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard want none");
            end else begin
                chk("sb_rdata", a_rdata, sb_q.pop_front());
            end
        end
        prev_rdy = (a_ready === 1'b1);
    end

    task automatic wait_ready_a(input string name, input int exp_k);
        bit got = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (a_ready === 1'b1) begin
                got = 1;
                chk(name, 32'(k), 32'(exp_k));
            end
        end
        if (!got) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_timeout: got no ready want ready", name);
        end
    endtask

    // Starts at a negedge with DUT A idle; returns at a negedge with DUT A idle.
    task automatic do_txn(input vec_t v, input bit perturb);
        a_req   = 1'b1;
        a_we    = v.we;
        a_be    = v.be;
        a_addr  = v.addr;
        a_wdata = v.wdata;
        sb_q.push_back(v.exp_rd);
        @(posedge clk);
        if (perturb) begin
            #1;
            a_addr  = 32'h08;
            a_we    = 1'b1;
            a_be    = 4'hF;
            a_wdata = 32'hFFFF_FFFF;
        end
        wait_ready_a("ready_latency", 2);
        a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit chk_data, input logic [31:0] exp);
        bit got = 0;
        b_req   = 1'b1;
        b_we    = we;
        b_addr  = addr;
        b_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (b_ready === 1'b1) begin
                got = 1;
                chk("b_latency", 32'(k), 32'd1);
                if (chk_data) chk("b_alias_rdata", b_rdata, exp);
            end
        end
        if (!got) begin
            n_total++;
            n_bad++;
            $display("FAIL b_timeout: got no ready want ready");
        end
        b_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1122_3344};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h1122_3344};
        vecs[3]  = '{1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0080, 32'h0000_0000, 32'h1234_5678};
        vecs[5]  = '{1'b1, 4'h4, 32'h0000_0080, 32'hABAB_ABAB, 32'h1234_5678};
        vecs[6]  = '{1'b1, 4'h1, 32'h0000_0080, 32'hCDCD_CDCD, 32'h1234_5678};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0080, 32'h0000_0000, 32'h00AB_00CD};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0080, 32'hFFFF_FFFF, 32'h00AB_00CD};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000_0080, 32'h0000_0000, 32'h00AB_00CD};
        vecs[10] = '{1'b1, 4'hF, 32'h0000_0004, 32'hA5A5_A5A5, 32'h00AB_00CD};
        vecs[11] = '{1'b1, 4'hF, 32'h0000_0008, 32'h5A5A_5A5A, 32'h00AB_00CD};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_0008, 32'h0000_0000, 32'h5A5A_5A5A};
        vecs[13] = '{1'b1, 4'hF, 32'h0000_1040, 32'hCAFE_F00D, 32'h5A5A_5A5A};
        vecs[14] = '{1'b0, 4'h0, 32'h0000_0043, 32'h0000_0000, 32'hCAFE_F00D};

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready_a", {31'b0, a_ready}, 32'd0);
        chk("reset_rdata_a", a_rdata, 32'd0);
        chk("reset_ready_b", {31'b0, b_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) do_txn(vecs[i], 1'b0);

        // Held request: acceptances at edges ending cycles 0,3,6,9.
        a_we = 1'b0; a_be = 4'h0; a_addr = 32'h40;
        for (int i = 0; i < 4; i++) sb_q.push_back(32'hCAFE_F00D);
        a_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("held_ready", {31'b0, a_ready}, 32'((c % 3) == 2));
        end
        @(posedge clk);
        #1 a_req = 1'b0;
        wait_ready_a("held_last_latency", 2);
        @(posedge clk);
        @(negedge clk);
        chk("held_sb_drained", 32'(sb_q.size()), 32'd0);

        // Input changes during WAIT must not affect the latched read.
        do_txn('{1'b0, 4'h0, 32'h04, 32'h0, 32'hA5A5_A5A5}, 1'b1);
        do_txn('{1'b0, 4'h0, 32'h08, 32'h0, 32'h5A5A_5A5A}, 1'b0);

        // Async reset during WAIT of a write discards it.
        a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", {31'b0, a_ready}, 32'd0);
        chk("async_rst_rdata", a_rdata, 32'd0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_no_ready", {31'b0, a_ready}, 32'd0);
        end
        do_txn('{1'b0, 4'h0, 32'h10, 32'h0, 32'h1122_3344}, 1'b0);

        // LATENCY=1 with address aliasing.
        txn_b(1'b1, 32'h0000_1004, 32'h55AA_55AA, 1'b0, 32'h0);
        txn_b(1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h55AA_55AA);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
